// File: rtl/seq_reduce_unit_pkg.sv
// Shared definitions for the sequential reduction unit: FSM state codes,
// operation codes and the per-operation accumulator identity.
package seq_reduce_unit_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      MODE_AND  = 2'b00,
      MODE_OR   = 2'b01,
      MODE_XOR  = 2'b10,
      MODE_NAND = 2'b11
   } mode_e;

   // NAND accumulates as AND, so it shares AND's identity.
   function automatic logic fold_identity(input mode_e mode);
      case (mode)
         MODE_AND, MODE_NAND: fold_identity = 1'b1;
         MODE_OR, MODE_XOR:   fold_identity = 1'b0;
         default:             fold_identity = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/seq_reduce_unit_if.sv
// Request/response bundle of the reduction unit: the requester drives
// start/mode/data, the unit returns busy/done/res.
interface seq_reduce_unit_if #(parameter int WIDTH = 16);

   logic             start;
   logic [1:0]       mode;
   logic [WIDTH-1:0] data;
   logic             busy;
   logic             done;
   logic             res;

   modport master (output start, mode, data, input busy, done, res);
   modport slave  (input start, mode, data, output busy, done, res);

endinterface

// File: rtl/seq_reduce_unit_chunk_fold.sv
// Combinational fold of one CHUNK-bit slice into the 1-bit accumulator,
// plus a flag telling the FSM the result can no longer change.
module chunk_fold
   import seq_reduce_unit_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic             acc,
   input  logic [CHUNK-1:0] chunk,
   input  mode_e            mode,
   output logic             acc_next,
   output logic             saturated
);

   // Fold the slice; AND/NAND saturate at 0, OR at 1, XOR never.
   always_comb begin
      acc_next  = acc;
      saturated = 1'b0;
      case (mode)
         MODE_AND, MODE_NAND: begin
            acc_next  = acc & (&chunk);
            saturated = ~acc_next;
         end
         MODE_OR: begin
            acc_next  = acc | (|chunk);
            saturated = acc_next;
         end
         MODE_XOR: begin
            acc_next  = acc ^ (^chunk);
            saturated = 1'b0;
         end
         default: begin
            acc_next  = acc;
            saturated = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seq_reduce_unit.sv
// Sequential bit-reduction (AND/OR/XOR/NAND) of a WIDTH-bit operand, CHUNK
// bits per cycle, with early termination once the result is decided.
module seq_reduce_unit
   import seq_reduce_unit_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic               clk,
   input  logic               rst,
   seq_reduce_unit_if.slave   bus
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if ((CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("seq_reduce_unit: WIDTH must be a whole multiple of CHUNK");
   end

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [WIDTH-1:0] data_r;
   mode_e            mode_r;
   logic [IDX_W-1:0] idx_r;
   logic             acc_r;
   logic             busy_r;
   logic             done_r;
   logic             res_r;

   logic [31:0]      offset_s;
   logic [CHUNK-1:0] chunk_s;
   logic             acc_fold_s;
   logic             sat_s;
   logic             last_s;

   assign offset_s = 32'(idx_r) * 32'(CHUNK);
   assign chunk_s  = CHUNK'(data_r >> offset_s);
   assign last_s   = (idx_r == IDX_W'(NCHUNK - 1));

   chunk_fold #(.CHUNK(CHUNK)) u_fold (
      .acc       (acc_r),
      .chunk     (chunk_s),
      .mode      (mode_r),
      .acc_next  (acc_fold_s),
      .saturated (sat_s)
   );

   // Next-state logic; start only matters in IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_s || sat_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, operand latches, chunk index, accumulator and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         data_r  <= '0;
         mode_r  <= MODE_AND;
         idx_r   <= '0;
         acc_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         res_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DONE);
         done_r  <= (state_nxt_s == ST_DONE);
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  data_r <= bus.data;
                  mode_r <= mode_e'(bus.mode);
                  idx_r  <= '0;
                  acc_r  <= fold_identity(mode_e'(bus.mode));
               end
            end
            ST_RUN: begin
               acc_r <= acc_fold_s;
               idx_r <= idx_r + IDX_W'(1);
               // res is only ever written on the way into DONE.
               if (state_nxt_s == ST_DONE) begin
                  res_r <= (mode_r == MODE_NAND) ? ~acc_fold_s : acc_fold_s;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.res  = res_r;

endmodule

// File: tb/tb_seq_reduce_unit.sv
// Directed self-checking bench for seq_reduce_unit (16/4 and 4/4 instances).
module tb_seq_reduce_unit;
   import seq_reduce_unit_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   seq_reduce_unit_if #(.WIDTH(16)) a ();
   seq_reduce_unit_if #(.WIDTH(4))  b ();

   seq_reduce_unit #(.WIDTH(16), .CHUNK(4)) u_dut  (.clk(clk), .rst(rst), .bus(a));
   seq_reduce_unit #(.WIDTH(4),  .CHUNK(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start on the 16-bit unit, wait for done; leaves the unit in IDLE.
   task automatic run_op(input logic [1:0] m, input logic [15:0] d, output int lat,
                         output int busy_cnt, output logic r, output logic stable);
      logic r0;
      r0 = a.res;
      stable = 1'b1;
      a.start = 1'b1; a.mode = m; a.data = d;
      tick();
      a.start = 1'b0;
      lat = 1; busy_cnt = 0;
      while (a.done !== 1'b1 && lat < 20) begin
         if (a.busy === 1'b1) busy_cnt++;
         if (a.res !== r0) stable = 1'b0;
         tick();
         lat++;
      end
      if (a.busy === 1'b1) busy_cnt++;
      r = a.res;
      tick();
   endtask

   task automatic run_op4(input logic [3:0] d, output int lat, output logic r);
      b.start = 1'b1; b.mode = MODE_AND; b.data = d;
      tick();
      b.start = 1'b0;
      lat = 1;
      while (b.done !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      r = b.res;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a.start = 1'b0; a.mode = MODE_AND; a.data = 16'h0000;
      b.start = 1'b0; b.mode = MODE_AND; b.data = 4'h0;
      tick(); tick();
      n_checks++; if (a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a.busy); end
      n_checks++; if (a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", a.done); end
      n_checks++; if (a.res !== 1'b0)  begin n_fail++; $display("FAIL reset_res: got %b want 0", a.res); end
      n_checks++; if (b.res !== 1'b0)  begin n_fail++; $display("FAIL reset_res4: got %b want 0", b.res); end
   endtask

   task automatic test_and_full();
      int lat, bc; logic r, st;
      rst = 1'b0;
      run_op(MODE_AND, 16'hFFFF, lat, bc, r, st);
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL and_full_latency: got %0d want 5", lat); end
      n_checks++; if (r !== 1'b1) begin n_fail++; $display("FAIL and_full_res: got %b want 1", r); end
      n_checks++; if (bc !== 5) begin n_fail++; $display("FAIL and_full_busy_cycles: got %0d want 5", bc); end
      n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL and_full_res_stable: got %b want 1", st); end
      n_checks++; if (a.busy !== 1'b0) begin n_fail++; $display("FAIL and_full_idle_busy: got %b want 0", a.busy); end
      n_checks++; if (a.done !== 1'b0) begin n_fail++; $display("FAIL and_full_idle_done: got %b want 0", a.done); end
      tick();
      n_checks++; if (a.res !== 1'b1) begin n_fail++; $display("FAIL and_full_res_hold: got %b want 1", a.res); end
   endtask

   task automatic test_short_circuit();
      int lat, bc; logic r, st;
      run_op(MODE_AND, 16'hFF0F, lat, bc, r, st);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL and_sc_latency: got %0d want 3", lat); end
      n_checks++; if (r !== 1'b0) begin n_fail++; $display("FAIL and_sc_res: got %b want 0", r); end
      n_checks++; if (bc !== 3) begin n_fail++; $display("FAIL and_sc_busy_cycles: got %0d want 3", bc); end
      n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL and_sc_res_stable: got %b want 1", st); end
      run_op(MODE_NAND, 16'hFF0F, lat, bc, r, st);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL nand_sc_latency: got %0d want 3", lat); end
      n_checks++; if (r !== 1'b1) begin n_fail++; $display("FAIL nand_sc_res: got %b want 1", r); end
      n_checks++; if (bc !== 3) begin n_fail++; $display("FAIL nand_sc_busy_cycles: got %0d want 3", bc); end
      n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL nand_sc_res_stable: got %b want 1", st); end
   endtask

   task automatic test_xor_or();
      int lat, bc; logic r, st;
      logic [1:0]  m_tab [4] = '{MODE_XOR, MODE_XOR, MODE_OR, MODE_OR};
      logic [15:0] d_tab [4] = '{16'h8001, 16'h8000, 16'h0000, 16'h0010};
      logic        r_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      int          l_tab [4] = '{5, 5, 5, 3};
      for (int i = 0; i < 4; i++) begin
         run_op(m_tab[i], d_tab[i], lat, bc, r, st);
         n_checks++; if (lat !== l_tab[i]) begin n_fail++; $display("FAIL xor_or_latency[%0d]: got %0d want %0d", i, lat, l_tab[i]); end
         n_checks++; if (r !== r_tab[i]) begin n_fail++; $display("FAIL xor_or_res[%0d]: got %b want %b", i, r, r_tab[i]); end
         n_checks++; if (bc !== l_tab[i]) begin n_fail++; $display("FAIL xor_or_busy_cycles[%0d]: got %0d want %0d", i, bc, l_tab[i]); end
         n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL xor_or_res_stable[%0d]: got %b want 1", i, st); end
      end
   endtask

   task automatic test_ignore_start();
      int dcnt, first; logic rv;
      dcnt = 0; first = 0; rv = 1'b0;
      a.start = 1'b1; a.mode = MODE_AND; a.data = 16'hFFFF;
      tick();
      a.start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (c == 2) begin a.start = 1'b1; a.data = 16'h0000; a.mode = MODE_OR; end
         if (c == 4) a.start = 1'b0;
         if (a.done === 1'b1) begin
            dcnt++;
            if (first == 0) begin first = c; rv = a.res; end
         end
         tick();
      end
      n_checks++; if (dcnt !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", dcnt); end
      n_checks++; if (first !== 5) begin n_fail++; $display("FAIL ignore_latency: got %0d want 5", first); end
      n_checks++; if (rv !== 1'b1) begin n_fail++; $display("FAIL ignore_res: got %b want 1", rv); end
   endtask

   task automatic test_reset_mid();
      int lat, bc; logic r, st;
      a.start = 1'b1; a.mode = MODE_AND; a.data = 16'hFFFF;
      tick();
      a.start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (a.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", a.busy); end
      n_checks++; if (a.done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", a.done); end
      n_checks++; if (a.res !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_res: got %b want 0", a.res); end
      // A stale done from the aborted operation would cut this latency short.
      run_op(MODE_AND, 16'hFFFF, lat, bc, r, st);
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL rst_mid_restart_latency: got %0d want 5", lat); end
      n_checks++; if (r !== 1'b1) begin n_fail++; $display("FAIL rst_mid_restart_res: got %b want 1", r); end
      n_checks++; if (bc !== 5) begin n_fail++; $display("FAIL rst_mid_restart_busy: got %0d want 5", bc); end
   endtask

   task automatic test_back_to_back();
      int lat;
      a.start = 1'b1; a.mode = MODE_AND; a.data = 16'hFFFF;
      tick();
      a.start = 1'b0; lat = 1;
      while (a.done !== 1'b1 && lat < 20) begin tick(); lat++; end
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 5", lat); end
      a.start = 1'b1; a.mode = MODE_AND; a.data = 16'hFF0F;
      tick();
      n_checks++; if (a.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done_busy: got %b want 0", a.busy); end
      tick();
      n_checks++; if (a.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy: got %b want 1", a.busy); end
      a.start = 1'b0; lat = 1;
      while (a.done !== 1'b1 && lat < 20) begin tick(); lat++; end
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 3", lat); end
      n_checks++; if (a.res !== 1'b0) begin n_fail++; $display("FAIL b2b_second_res: got %b want 0", a.res); end
      tick();
   endtask

   task automatic test_width4();
      int lat; logic r;
      logic [3:0] d_tab [4] = '{4'b0000, 4'b1001, 4'b0110, 4'b1111};
      logic       r_tab [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         run_op4(d_tab[i], lat, r);
         n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL w4_latency[%0d]: got %0d want 2", i, lat); end
         n_checks++; if (r !== r_tab[i]) begin n_fail++; $display("FAIL w4_res[%0d]: got %b want %b", i, r, r_tab[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_and_full();
      test_short_circuit();
      test_xor_or();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_width4();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
